// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer scan reader: FSM states,
// RGB444 field positions and the nibble-replicating colour expansion.
`default_nettype none

package fb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      PRIME = 2'd2,
      RUN   = 2'd3
   } state_t;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   localparam int R_MSB = 11;
   localparam int R_LSB = 8;
   localparam int G_MSB = 7;
   localparam int G_LSB = 4;
   localparam int B_MSB = 3;
   localparam int B_LSB = 0;

   function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
      return {c[R_MSB:R_LSB], c[R_MSB:R_LSB],
              c[G_MSB:G_LSB], c[G_MSB:G_LSB],
              c[B_MSB:B_LSB], c[B_MSB:B_LSB]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fb_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched RGB444 pixels; flush empties it
// in one cycle and takes priority over any push/pop in the same cycle.
`default_nettype none

module fb_prefetch_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 12,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fb_scan_reader.sv
// Streams RGB444 words from the SDRAM read FIFO through a prefetch buffer and
// emits one pixel per VGA strobe; reloads the read address once per frame.
`default_nettype none

module fb_scan_reader
   import fb_pkg::*;
#(
   parameter int          DEPTH    = 16,
   parameter int          H_ACTIVE = H_ACTIVE_DEF,
   parameter int          V_ACTIVE = V_ACTIVE_DEF,
   parameter logic [11:0] UF_COLOR = 12'hF0F
) (
   input  logic        Clk,
   input  logic        RESET_N,
   input  logic        pix_en,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        rd_empty,
   input  logic [15:0] rd_data,
   output logic        rd,
   output logic        rd_load,
   output logic [7:0]  Red,
   output logic [7:0]  Green,
   output logic [7:0]  Blue,
   output logic        underflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t        state_q, state_d;
   logic          rd_q;
   logic [23:0]   rgb_q, rgb_d;
   logic          underflow_q, underflow_d;

   logic          fifo_flush, fifo_push, fifo_pop;
   logic [11:0]   fifo_head;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;

   logic          active, frame_start, origin, fetching, pop_en;
   logic          unused_hi;

   // Upper nibble of each frame-buffer word carries no colour.
   assign unused_hi = ^rd_data[15:12];

   assign active      = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
   assign frame_start = pix_en && (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
   assign origin      = pix_en && (DrawX == 10'd0) && (DrawY == 10'd0);
   assign fifo_empty  = (fifo_count == '0);
   assign fetching    = (state_q == PRIME) || (state_q == RUN);

   // The origin strobe that forces PRIME into RUN also consumes pixel (0,0).
   assign pop_en = pix_en && active &&
                   ((state_q == RUN) || ((state_q == PRIME) && origin));

   // Count the read still in flight so the buffer can never be overfilled.
   assign rd = fetching && !rd_empty && ((fifo_count + CW'(rd_q)) < CW'(DEPTH));

   assign fifo_flush = (state_q == LOAD);
   assign fifo_push  = rd_q;
   assign fifo_pop   = pop_en && !fifo_empty;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_start) state_d = LOAD;
         LOAD:    state_d = PRIME;
         PRIME:   if ((fifo_count == CW'(DEPTH)) || origin) state_d = RUN;
         RUN:     if (frame_start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rgb_d       = rgb_q;
      underflow_d = underflow_q;
      if (pix_en) begin
         if (pop_en) begin
            if (fifo_empty) begin
               rgb_d       = rgb444_to_888(UF_COLOR);
               underflow_d = 1'b1;
            end else begin
               rgb_d = rgb444_to_888(fifo_head);
            end
         end else begin
            rgb_d = '0;
         end
      end
   end

   always_ff @(posedge Clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         rd_q        <= 1'b0;
         rgb_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd;
         rgb_q       <= rgb_d;
         underflow_q <= underflow_d;
      end
   end

   fb_prefetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (12)
   ) u_fifo (
      .clk       (Clk),
      .rst_n     (RESET_N),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (rd_data[11:0]),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign rd_load   = (state_q == LOAD);
   assign Red       = rgb_q[23:16];
   assign Green     = rgb_q[15:8];
   assign Blue      = rgb_q[7:0];
   assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_scan_reader.sv
// Scoreboard bench for fb_scan_reader on a reduced 8x6 raster (12x9 total).
`default_nettype none

module tb_fb_scan_reader;

   localparam int          DEPTH = 16;
   localparam int          H_ACT = 8;
   localparam int          V_ACT = 6;
   localparam int          H_TOT = 12;
   localparam int          V_TOT = 9;
   localparam logic [11:0] UF    = 12'hF0F;

   logic        Clk = 1'b0;
   logic        RESET_N = 1'b0;
   logic        pix_en = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        rd_empty = 1'b1;
   logic [15:0] rd_data = '0;
   logic        rd, rd_load, underflow;
   logic [7:0]  Red, Green, Blue;

   int          errors = 0;
   int          checks = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_v;
   int          load_cnt = 0, load_run = 0, load_run_max = 0;
   int          rd_watch_cnt = 0;
   bit          rd_watch = 0;
   int          src_idx = 0;
   bit          rd_pend = 0;
   int          overflow_events = 0;
   int          pushpop_seen = 0;
   logic [4:0]  pp_count;

   fb_scan_reader #(
      .DEPTH    (DEPTH),
      .H_ACTIVE (H_ACT),
      .V_ACTIVE (V_ACT),
      .UF_COLOR (UF)
   ) u_dut (
      .Clk       (Clk),
      .RESET_N   (RESET_N),
      .pix_en    (pix_en),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .rd_empty  (rd_empty),
      .rd_data   (rd_data),
      .rd        (rd),
      .rd_load   (rd_load),
      .Red       (Red),
      .Green     (Green),
      .Blue      (Blue),
      .underflow (underflow)
   );

   always #10 Clk = ~Clk;

   function automatic logic [15:0] word(input int i);
      case (i)
         0:       return 16'h0F00;
         1:       return 16'h00F0;
         2:       return 16'h000F;
         default: return {4'h5, 12'(i)};
      endcase
   endfunction

   function automatic logic [23:0] rgb(input logic [11:0] c);
      return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
   endfunction

   // mode 1: words in raster order; mode 2: row 0 underflows, data starts at row 1.
   function automatic logic [23:0] expected(input int mode, input int rst_row,
                                            input int x, input int y);
      logic [15:0] w;
      if (x >= H_ACT || y >= V_ACT) return 24'h0;
      if (rst_row >= 0 && y > rst_row) return 24'h0;
      if (mode == 2) begin
         if (y == 0) return rgb(UF);
         w = word((y - 1) * H_ACT + x);
         return rgb(w[11:0]);
      end
      w = word(y * H_ACT + x);
      return rgb(w[11:0]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // SDRAM read FIFO model: data appears the cycle after a pop request.
   always @(negedge Clk) begin
      if (rd_pend) begin
         rd_data = word(src_idx);
         src_idx++;
      end
      rd_pend = rd;
      if (rd_load) begin
         src_idx = 0;
         load_cnt++;
         load_run++;
         if (load_run > load_run_max) load_run_max = load_run;
      end else begin
         load_run = 0;
      end
      if (rd_watch && rd) rd_watch_cnt++;
   end

   // Pixel monitor: every strobe produces a registered output one Clk later.
   always @(posedge Clk) begin
      if (pix_en) begin
         #1;
         if (exp_q.size() == 0) begin
            check("scoreboard_underrun", 32'd1, 32'd0);
         end else begin
            exp_v = exp_q.pop_front();
            check("pixel_rgb", {8'h0, Red, Green, Blue}, {8'h0, exp_v});
         end
      end
   end

   always @(posedge Clk) begin
      if (RESET_N) begin
         assert (!(u_dut.fifo_push && !u_dut.fifo_flush && u_dut.fifo_count == 5'(DEPTH)))
         else begin
            overflow_events++;
            $display("FAIL push_when_full: count=%0d", u_dut.fifo_count);
         end
         if (u_dut.fifo_count > 5'(DEPTH)) begin
            overflow_events++;
            $display("FAIL count_bound: count=%0d max %0d", u_dut.fifo_count, DEPTH);
         end
         if (u_dut.fifo_push && u_dut.fifo_pop && !u_dut.fifo_flush) begin
            pp_count = u_dut.fifo_count;
            pushpop_seen++;
            #1;
            check("pushpop_count", 32'(u_dut.fifo_count), 32'(pp_count));
         end
      end
   end

   task automatic run_frame(input int mode, input int rst_row, input bit rnd);
      int  l0, lr;
      int  y;
      bit  force_empty;
      l0 = load_cnt;
      lr = 0;
      for (int k = 0; k < V_TOT; k++) begin
         y = (k + V_ACT) % V_TOT;
         for (int x = 0; x < H_TOT; x++) begin
            force_empty = (mode == 2) && (y >= V_ACT || (y == 0 && x < H_ACT));
            @(posedge Clk); #2;
            if (mode == 2 && y == 1 && x == 0) check("underflow_set", 32'(underflow), 32'd1);
            if (y == rst_row && x == H_ACT) begin
               check("underflow_sticky", 32'(underflow), 32'd1);
               RESET_N = 1'b0;
            end
            pix_en   = 1'b1;
            DrawX    = 10'(x);
            DrawY    = 10'(y);
            rd_empty = force_empty ? 1'b1 : (rnd ? ($urandom_range(0, 3) == 0) : 1'b0);
            exp_q.push_back(expected(mode, rst_row, x, y));
            @(posedge Clk); #2;
            pix_en = 1'b0;
            if (!force_empty && rnd) rd_empty = ($urandom_range(0, 3) == 0);
            if (!RESET_N) begin
               RESET_N = 1'b1;
               #1;
               check("rst_underflow_clr", 32'(underflow), 32'd0);
               check("rst_rd_low", 32'(rd), 32'd0);
               check("rst_rgb_zero", {8'h0, Red, Green, Blue}, 32'd0);
               rd_watch     = 1;
               rd_watch_cnt = 0;
               lr           = load_cnt;
            end
         end
      end
      check("rd_load_per_frame", 32'(load_cnt - l0), 32'd1);
      if (rst_row >= 0) begin
         rd_watch = 0;
         check("idle_no_rd", 32'(rd_watch_cnt), 32'd0);
         check("idle_no_rd_load", 32'(load_cnt - lr), 32'd0);
      end
   endtask

   initial begin
      #(100000 * 20);
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge Clk);
      #2;
      check("reset_rgb", {8'h0, Red, Green, Blue}, 32'd0);
      check("reset_rd", 32'(rd), 32'd0);
      check("reset_rd_load", 32'(rd_load), 32'd0);
      check("reset_underflow", 32'(underflow), 32'd0);
      RESET_N  = 1'b1;
      rd_empty = 1'b0;

      run_frame(1, -1, 1'b0);
      check("rd_load_width", 32'(load_run_max), 32'd1);
      run_frame(1, -1, 1'b1);
      run_frame(1, -1, 1'b1);
      check("no_underflow_yet", 32'(underflow), 32'd0);
      run_frame(2, -1, 1'b0);
      check("underflow_held", 32'(underflow), 32'd1);
      run_frame(1, 3, 1'b1);
      rd_empty = 1'b0;
      run_frame(1, -1, 1'b0);
      check("rd_load_width_all", 32'(load_run_max), 32'd1);

      repeat (3) @(posedge Clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("no_overflow", 32'(overflow_events), 32'd0);
      check("pushpop_exercised", 32'(pushpop_seen > 0), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
